dport_sram_bridge: RTL and testbench

//   Sits directly downstream of the merlin32i core data port, between the core
//   and a single-port synchronous SRAM. It accepts core load/store requests over
//   the dreq valid/ready handshake and generates byte enables and lane-placed

---
 rtl/dport_sram_bridge.sv | 158 +++++++++++++++
 tb/tb_dport_sram_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dport_sram_bridge.sv
// Core data-port to single-port SRAM bridge: checks alignment and range, places
// byte lanes, and returns one in-order response per request through a small FIFO.
module dport_sram_bridge #(
    parameter int C_ADDR_WIDTH  = 12,
    parameter int C_RSP_DEPTH_X = 2
) (
    input  logic                    clk_i,
    input  logic                    resetb_i,
    input  logic                    clk_en_i,
    output logic                    dreqready_o,
    input  logic                    dreqvalid_i,
    input  logic [1:0]              dreqsize_i,
    input  logic                    dreqwrite_i,
    input  logic [1:0]              dreqhpl_i,
    input  logic [31:0]             dreqaddr_i,
    input  logic [31:0]             dreqdata_i,
    input  logic                    drspready_i,
    output logic                    drspvalid_o,
    output logic                    drsprerr_o,
    output logic                    drspwerr_o,
    output logic [31:0]             drspdata_o,
    output logic                    sram_en_o,
    output logic                    sram_wr_o,
    output logic [3:0]              sram_be_o,
    output logic [C_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]             sram_wdata_o,
    input  logic [31:0]             sram_rdata_i
);
    localparam int DEPTH = 1 << C_RSP_DEPTH_X;
    localparam int PW    = C_RSP_DEPTH_X;
    localparam int CW    = C_RSP_DEPTH_X + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    typedef struct packed {
        logic        rerr;
        logic        werr;
        logic [31:0] data;
    } rsp_t;

    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wptr, rptr;
    rsp_t          fifo_mem [DEPTH];
    rsp_t          push_ent, head;

    logic       s1_valid, s1_write, s1_err;
    logic [1:0] s1_size, s1_lane;

    logic        acc, req_err, push, pop;
    logic [CW:0] occ;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw, rd_shift, rd_fmt;

    // Privilege level travels with the request but is not checked here.
    logic unused_hpl;
    assign unused_hpl = ^dreqhpl_i;

    // Occupancy counts the response still in s1; a same-cycle pop is not credited.
    assign occ         = {1'b0, fifo_count} + (CW+1)'(s1_valid);
    assign dreqready_o = clk_en_i & (occ < DEPTH_V);
    assign acc         = dreqvalid_i & dreqready_o;

    assign req_err = (dreqsize_i == 2'd3)
                   | ((dreqsize_i == 2'd1) & dreqaddr_i[0])
                   | ((dreqsize_i == 2'd2) & (|dreqaddr_i[1:0]))
                   | (|dreqaddr_i[31:C_ADDR_WIDTH+2]);

    always_comb begin
        be_raw    = 4'b1111;
        wdata_raw = dreqdata_i;
        unique case (dreqsize_i)
            2'd0: begin
                be_raw    = 4'b0001 << dreqaddr_i[1:0];
                wdata_raw = {4{dreqdata_i[7:0]}};
            end
            2'd1: begin
                be_raw    = 4'b0011 << dreqaddr_i[1:0];
                wdata_raw = {2{dreqdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign sram_en_o    = acc & ~req_err;
    assign sram_wr_o    = sram_en_o & dreqwrite_i;
    assign sram_be_o    = sram_en_o ? be_raw : 4'b0000;
    assign sram_addr_o  = sram_en_o ? dreqaddr_i[C_ADDR_WIDTH+1:2] : '0;
    assign sram_wdata_o = sram_wr_o ? wdata_raw : 32'h0;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            s1_valid <= 1'b0;
            s1_write <= 1'b0;
            s1_err   <= 1'b0;
            s1_size  <= 2'd0;
            s1_lane  <= 2'd0;
        end else if (clk_en_i) begin
            s1_valid <= acc;
            if (acc) begin
                s1_write <= dreqwrite_i;
                s1_err   <= req_err;
                s1_size  <= dreqsize_i;
                s1_lane  <= dreqaddr_i[1:0];
            end
        end
    end

    // SRAM read data arrives one edge after the access; right-align and zero-extend.
    assign rd_shift = sram_rdata_i >> {s1_lane, 3'b000};

    always_comb begin
        rd_fmt = rd_shift;
        unique case (s1_size)
            2'd0:    rd_fmt = {24'h0, rd_shift[7:0]};
            2'd1:    rd_fmt = {16'h0, rd_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        push_ent = '0;
        if (s1_err) begin
            push_ent.rerr = ~s1_write;
            push_ent.werr = s1_write;
        end else if (!s1_write) begin
            push_ent.data = rd_fmt;
        end
    end

    assign push = clk_en_i & s1_valid;
    assign pop  = drspvalid_o & drspready_i;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr] <= push_ent;
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head        = fifo_mem[rptr];
    assign drspvalid_o = clk_en_i & (fifo_count != '0);
    assign drsprerr_o  = drspvalid_o & head.rerr;
    assign drspwerr_o  = drspvalid_o & head.werr;
    assign drspdata_o  = drspvalid_o ? head.data : 32'h0;

endmodule

// File: tb/tb_dport_sram_bridge.sv
// Directed bench for dport_sram_bridge with a behavioural SRAM and a byte-level reference memory.
module tb_dport_sram_bridge;
    localparam int AW = 12;

    logic          clk_i = 1'b0;
    logic          resetb_i, clk_en_i;
    logic          dreqready_o, dreqvalid_i, dreqwrite_i;
    logic [1:0]    dreqsize_i, dreqhpl_i;
    logic [31:0]   dreqaddr_i, dreqdata_i;
    logic          drspready_i, drspvalid_o, drsprerr_o, drspwerr_o;
    logic [31:0]   drspdata_o;
    logic          sram_en_o, sram_wr_o;
    logic [3:0]    sram_be_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    dport_sram_bridge #(.C_ADDR_WIDTH(AW), .C_RSP_DEPTH_X(2)) dut (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqsize_i(dreqsize_i),
        .dreqwrite_i(dreqwrite_i), .dreqhpl_i(dreqhpl_i), .dreqaddr_i(dreqaddr_i),
        .dreqdata_i(dreqdata_i), .drspready_i(drspready_i), .drspvalid_o(drspvalid_o),
        .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o), .drspdata_o(drspdata_o),
        .sram_en_o(sram_en_o), .sram_wr_o(sram_wr_o), .sram_be_o(sram_be_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous single-port SRAM; rdata holds unless a read is issued.
    logic [31:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk_i) begin
        if (sram_en_o) begin
            if (sram_wr_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        dreqvalid_i = v;
        dreqwrite_i = w;
        dreqsize_i  = sz;
        dreqaddr_i  = a;
        dreqdata_i  = d;
    endtask

    task automatic test_reset();
        resetb_i = 1'b0; clk_en_i = 1'b1; drspready_i = 1'b0; dreqhpl_i = 2'b11;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);
        #1;
        n_cmp++; if (dreqready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", dreqready_o); end
        n_cmp++; if (drspvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_rspvalid: got %b want 0", drspvalid_o); end
        n_cmp++; if ({sram_en_o, sram_wr_o, sram_be_o} !== 6'b0) begin n_err++; $display("FAIL reset_sram: got %b%b%h want 0", sram_en_o, sram_wr_o, sram_be_o); end
        @(negedge clk_i);
        resetb_i = 1'b1;
    endtask

    task automatic test_store_load_word();
        drspready_i = 1'b1;
        @(negedge clk_i); drive(1, 1, 2'd2, 32'h10, 32'hDEADBEEF); #1;
        n_cmp++; if ({sram_en_o, sram_wr_o} !== 2'b11) begin n_err++; $display("FAIL t1_en_wr: got %b%b want 11", sram_en_o, sram_wr_o); end
        n_cmp++; if (sram_be_o !== 4'hF) begin n_err++; $display("FAIL t1_be: got %h want f", sram_be_o); end
        n_cmp++; if (sram_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL t1_wdata: got %h want deadbeef", sram_wdata_o); end
        n_cmp++; if (sram_addr_o !== 12'h004) begin n_err++; $display("FAIL t1_addr: got %h want 004", sram_addr_o); end
        @(negedge clk_i); drive(1, 0, 2'd2, 32'h10, 32'h0); #1;
        n_cmp++; if (drspvalid_o !== 1'b0) begin n_err++; $display("FAIL t1_early_rsp: got %b want 0", drspvalid_o); end
        n_cmp++; if ({sram_en_o, sram_wr_o} !== 2'b10) begin n_err++; $display("FAIL t1_rd_en: got %b%b want 10", sram_en_o, sram_wr_o); end
        @(negedge clk_i); drive(0, 0, 2'd0, 32'h0, 32'h0); #1;
        n_cmp++; if ({drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o} !== {3'b100, 32'h0}) begin n_err++; $display("FAIL t1_st_rsp: got %b%b%b %h want 100 0", drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o); end
        @(negedge clk_i); #1;
        n_cmp++; if ({drspvalid_o, drsprerr_o, drspdata_o} !== {2'b10, 32'hDEADBEEF}) begin n_err++; $display("FAIL t1_ld_rsp: got %b%b %h want 10 deadbeef", drspvalid_o, drsprerr_o, drspdata_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (drspvalid_o !== 1'b0) begin n_err++; $display("FAIL t1_drain: got %b want 0", drspvalid_o); end
    endtask

    task automatic test_byte_half();
        @(negedge clk_i); drive(1, 1, 2'd0, 32'h13, 32'h123456A5); #1;
        n_cmp++; if (sram_be_o !== 4'b1000) begin n_err++; $display("FAIL t2_be_byte: got %b want 1000", sram_be_o); end
        n_cmp++; if (sram_wdata_o !== 32'hA5A5A5A5) begin n_err++; $display("FAIL t2_wdata: got %h want a5a5a5a5", sram_wdata_o); end
        @(negedge clk_i); drive(1, 0, 2'd1, 32'h12, 32'h0); #1;
        n_cmp++; if (sram_be_o !== 4'b1100) begin n_err++; $display("FAIL t2_be_half: got %b want 1100", sram_be_o); end
        @(negedge clk_i); drive(0, 0, 2'd0, 32'h0, 32'h0); #1;
        n_cmp++; if ({drspvalid_o, drspwerr_o, drspdata_o} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL t2_st_rsp: got %b%b %h want 10 0", drspvalid_o, drspwerr_o, drspdata_o); end
        @(negedge clk_i); #1;
        n_cmp++; if ({drspvalid_o, drspdata_o} !== {1'b1, 32'h0000A5AD}) begin n_err++; $display("FAIL t2_ld_half: got %b %h want 1 0000a5ad", drspvalid_o, drspdata_o); end
        @(negedge clk_i);
    endtask

    task automatic test_errors();
        logic        w  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] ad [4] = '{32'h1, 32'h2, 32'h0, 32'h1 << (AW+2)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (i < 4) drive(1, w[i], sz[i], ad[i], 32'hFFFF_FFFF);
            else drive(0, 0, 2'd0, 32'h0, 32'h0);
            #1;
            if (i < 4) begin
                n_cmp++; if ({dreqready_o, sram_en_o, sram_be_o} !== 6'b100000) begin n_err++; $display("FAIL t3_no_access[%0d]: got rdy=%b en=%b be=%b want 1 0 0", i, dreqready_o, sram_en_o, sram_be_o); end
            end
            if (i >= 2) begin
                n_cmp++;
                if ({drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o} !== {1'b1, ~w[i-2], w[i-2], 32'h0}) begin
                    n_err++; $display("FAIL t3_err_rsp[%0d]: got v=%b r=%b w=%b d=%h want 1 %b %b 0", i-2, drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o, ~w[i-2], w[i-2]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got = 0;
        drspready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            if (i < 6) drive(1, 1, 2'd2, 32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i));
            else drive(0, 0, 2'd0, 32'h0, 32'h0);
        end
        drspready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (idx < 6) drive(1, 0, 2'd2, 32'h100 + 32'(4*idx), 32'h0);
            else drive(0, 0, 2'd0, 32'h0, 32'h0);
            #1;
            if (dreqvalid_i && dreqready_o) idx++;
        end
        n_cmp++; if (idx !== 4) begin n_err++; $display("FAIL t4_accepted: got %0d want 4", idx); end
        n_cmp++; if ({dreqready_o, drspvalid_o} !== 2'b01) begin n_err++; $display("FAIL t4_stall: got rdy=%b vld=%b want 0 1", dreqready_o, drspvalid_o); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            drspready_i = 1'b1;
            if (idx < 6) drive(1, 0, 2'd2, 32'h100 + 32'(4*idx), 32'h0);
            else drive(0, 0, 2'd0, 32'h0, 32'h0);
            #1;
            if (c == 0) begin
                n_cmp++; if (dreqready_o !== 1'b0) begin n_err++; $display("FAIL t4_pop_credit: got %b want 0", dreqready_o); end
            end
            if (drspvalid_o) begin
                n_cmp++; if (drspdata_o !== 32'hC0DE0000 + 32'(got)) begin n_err++; $display("FAIL t4_order[%0d]: got %h want %h", got, drspdata_o, 32'hC0DE0000 + 32'(got)); end
                got++;
            end
            if (dreqvalid_i && dreqready_o) idx++;
        end
        n_cmp++; if (got !== 6 || idx !== 6) begin n_err++; $display("FAIL t4_totals: got rsp=%0d acc=%0d want 6 6", got, idx); end
    endtask

    task automatic test_stream();
        logic [7:0]  ref_mem [64];
        logic [31:0] exp_q [$];
        logic [31:0] d, e;
        logic        w;
        logic [1:0]  sz;
        int          off;
        int          nrsp = 0;
        drspready_i = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk_i);
            if (i < 100) begin
                d = $urandom;
                if (i < 16) begin
                    w = 1'b1; sz = 2'd2; off = 4*i;
                end else begin
                    w   = 1'($urandom_range(0, 1));
                    sz  = 2'($urandom_range(0, 2));
                    off = 4*int'($urandom_range(0, 15));
                    if (sz == 2'd0) off += int'($urandom_range(0, 3));
                    if (sz == 2'd1) off += 2*int'($urandom_range(0, 1));
                end
                e = 32'h0;
                if (w) begin
                    ref_mem[off] = d[7:0];
                    if (sz != 2'd0) ref_mem[off+1] = d[15:8];
                    if (sz == 2'd2) begin ref_mem[off+2] = d[23:16]; ref_mem[off+3] = d[31:24]; end
                end else begin
                    e[7:0] = ref_mem[off];
                    if (sz != 2'd0) e[15:8] = ref_mem[off+1];
                    if (sz == 2'd2) e[31:16] = {ref_mem[off+3], ref_mem[off+2]};
                end
                exp_q.push_back(e);
                drive(1, w, sz, 32'h800 + 32'(off), d);
                #1;
                n_cmp++; if (dreqready_o !== 1'b1) begin n_err++; $display("FAIL t5_ready[%0d]: got %b want 1", i, dreqready_o); end
            end else begin
                drive(0, 0, 2'd0, 32'h0, 32'h0);
                #1;
            end
            if (drspvalid_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL t5_extra_rsp: got data %h want none", drspdata_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({drsprerr_o, drspwerr_o, drspdata_o} !== {2'b00, e}) begin
                        n_err++; $display("FAIL t5_data[%0d]: got r=%b w=%b d=%h want 0 0 %h", nrsp, drsprerr_o, drspwerr_o, drspdata_o, e);
                    end
                end
                nrsp++;
            end
        end
        n_cmp++; if (nrsp !== 100 || exp_q.size() != 0) begin n_err++; $display("FAIL t5_count: got %0d rsp, %0d left want 100, 0", nrsp, exp_q.size()); end
    endtask

    task automatic test_clk_en();
        drspready_i = 1'b0;
        @(negedge clk_i); drive(1, 0, 2'd2, 32'h10, 32'h0);
        @(negedge clk_i); drive(0, 0, 2'd0, 32'h0, 32'h0);
        @(negedge clk_i);
        clk_en_i = 1'b0; drspready_i = 1'b1;
        drive(1, 1, 2'd2, 32'h20, 32'h11111111);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if ({dreqready_o, drspvalid_o, sram_en_o} !== 3'b000) begin n_err++; $display("FAIL te_gated[%0d]: got rdy=%b vld=%b en=%b want 000", c, dreqready_o, drspvalid_o, sram_en_o); end
            @(negedge clk_i);
        end
        clk_en_i = 1'b1;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        #1;
        n_cmp++; if ({drspvalid_o, drspdata_o} !== {1'b1, 32'hA5ADBEEF}) begin n_err++; $display("FAIL te_held: got %b %h want 1 a5adbeef", drspvalid_o, drspdata_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (drspvalid_o !== 1'b0) begin n_err++; $display("FAIL te_drain: got %b want 0", drspvalid_o); end
    endtask

    task automatic test_reset_midop();
        drspready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); drive(1, 0, 2'd2, 32'h10, 32'h0);
        end
        @(negedge clk_i); drive(0, 0, 2'd0, 32'h0, 32'h0); #1;
        n_cmp++; if ({dreqready_o, drspvalid_o} !== 2'b01) begin n_err++; $display("FAIL t6_full: got rdy=%b vld=%b want 0 1", dreqready_o, drspvalid_o); end
        resetb_i = 1'b0; #1;
        n_cmp++; if ({drspvalid_o, sram_en_o} !== 2'b00) begin n_err++; $display("FAIL t6_in_reset: got vld=%b en=%b want 0 0", drspvalid_o, sram_en_o); end
        @(negedge clk_i); resetb_i = 1'b1; #1;
        n_cmp++; if ({drspvalid_o, dreqready_o} !== 2'b01) begin n_err++; $display("FAIL t6_after: got vld=%b rdy=%b want 0 1", drspvalid_o, dreqready_o); end
        drspready_i = 1'b1;
        @(negedge clk_i); drive(1, 0, 2'd2, 32'h10, 32'h0);
        @(negedge clk_i); drive(0, 0, 2'd0, 32'h0, 32'h0);
        @(negedge clk_i); #1;
        n_cmp++; if ({drspvalid_o, drspdata_o} !== {1'b1, 32'hA5ADBEEF}) begin n_err++; $display("FAIL t6_reuse: got %b %h want 1 a5adbeef", drspvalid_o, drspdata_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store_load_word();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_stream();
        test_clk_en();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
